// File: rtl/sequence_pkg.sv
// Shared types and constants for the sequence scheduler and its step counter.
package sequence_pkg;

    localparam int SEQ_WORD_W = 128;

    // All-zero word: every enable off in the sequence slice.
    localparam logic [SEQ_WORD_W-1:0] IDLE_WORD = '0;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FETCH0 = 2'd1,
        ST_FETCH1 = 2'd2,
        ST_RUN    = 2'd3
    } seq_state_e;

endpackage

// File: rtl/sequence_scheduler_if.sv
// Sequence RAM read port: address/enable out, data returned one clock after rd_en.
interface sequence_scheduler_if #(
    parameter int ADDR_WIDTH = 10
);
    import sequence_pkg::*;

    logic                  rd_en;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic [SEQ_WORD_W-1:0] rd_data;

    modport master (output rd_en, output rd_addr, input rd_data);
    modport slave  (input rd_en, input rd_addr, output rd_data);

endinterface

// File: rtl/sequence_step_counter.sv
// Per-step sample counter; hold length clamps to a minimum of 2 so a prefetch slot always exists.
module sequence_step_counter #(
    parameter int CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 aresetn,
    input  logic                 run,
    input  logic [CNT_WIDTH-1:0] samples_per_step,
    output logic [CNT_WIDTH-1:0] count,
    output logic                 prefetch,
    output logic                 last
);

    logic [CNT_WIDTH-1:0] count_q;
    logic [CNT_WIDTH-1:0] count_d;
    logic [CNT_WIDTH-1:0] span;

    always_comb begin
        span     = (samples_per_step < CNT_WIDTH'(2)) ? CNT_WIDTH'(2) : samples_per_step;
        prefetch = (count_q == span - CNT_WIDTH'(2));
        last     = (count_q == span - CNT_WIDTH'(1));
        count_d  = '0;
        if (run && !last) begin
            count_d = count_q + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/sequence_scheduler.sv
// Plays a table of sequence words from RAM, holding each for S clocks and repeating the table.
module sequence_scheduler
    import sequence_pkg::*;
#(
    parameter int ADDR_WIDTH = 10,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                  clk,
    input  logic                  aresetn,
    input  logic                  start,
    input  logic                  stop,
    input  logic [ADDR_WIDTH:0]   num_steps,
    input  logic [CNT_WIDTH-1:0]  samples_per_step,
    input  logic [CNT_WIDTH-1:0]  num_repetitions,
    sequence_scheduler_if.master  ram,
    output logic [SEQ_WORD_W-1:0] seq_data,
    output logic                  busy,
    output logic [ADDR_WIDTH-1:0] step_idx,
    output logic [CNT_WIDTH-1:0]  rep_idx,
    output logic                  done,
    output logic [1:0]            state_dbg
);

    seq_state_e            state_q, state_d;
    logic [SEQ_WORD_W-1:0] seq_data_q, seq_data_d;
    logic [ADDR_WIDTH-1:0] step_idx_q, step_idx_d;
    logic [CNT_WIDTH-1:0]  rep_idx_q, rep_idx_d;
    logic                  done_q, done_d;
    logic [ADDR_WIDTH:0]   num_steps_q, num_steps_d;
    logic [CNT_WIDTH-1:0]  sps_q, sps_d;
    logic [CNT_WIDTH-1:0]  nreps_q, nreps_d;

    logic [CNT_WIDTH-1:0]  step_count;
    logic                  prefetch;
    logic                  last;
    logic                  wrap;
    logic [ADDR_WIDTH-1:0] next_idx;
    logic [CNT_WIDTH-1:0]  rep_inc;
    logic                  table_end;
    logic                  count_run;

    sequence_step_counter #(.CNT_WIDTH(CNT_WIDTH)) u_step_counter (
        .clk              (clk),
        .aresetn          (aresetn),
        .run              (count_run),
        .samples_per_step (sps_q),
        .count            (step_count),
        .prefetch         (prefetch),
        .last             (last)
    );

    // rep_inc only saturates in infinite mode; with a finite count it ends before all-ones.
    always_comb begin
        wrap      = ({1'b0, step_idx_q} == (num_steps_q - (ADDR_WIDTH+1)'(1)));
        next_idx  = wrap ? '0 : step_idx_q + ADDR_WIDTH'(1);
        rep_inc   = (&rep_idx_q) ? rep_idx_q : rep_idx_q + CNT_WIDTH'(1);
        table_end = (state_q == ST_RUN) && last && wrap &&
                    (nreps_q != '0) && (rep_inc == nreps_q);
        count_run = (state_q == ST_RUN) && !stop && !table_end;
    end

    always_comb begin
        state_d     = state_q;
        seq_data_d  = seq_data_q;
        step_idx_d  = step_idx_q;
        rep_idx_d   = rep_idx_q;
        done_d      = 1'b0;
        num_steps_d = num_steps_q;
        sps_d       = sps_q;
        nreps_d     = nreps_q;
        case (state_q)
            ST_IDLE: begin
                seq_data_d = IDLE_WORD;
                if (start && !stop && (num_steps != '0)) begin
                    num_steps_d = num_steps;
                    sps_d       = samples_per_step;
                    nreps_d     = num_repetitions;
                    step_idx_d  = '0;
                    rep_idx_d   = '0;
                    state_d     = ST_FETCH0;
                end
            end
            ST_FETCH0: state_d = ST_FETCH1;
            ST_FETCH1: begin
                seq_data_d = ram.rd_data;
                step_idx_d = '0;
                state_d    = ST_RUN;
            end
            ST_RUN: begin
                if (last) begin
                    if (wrap) begin
                        rep_idx_d = rep_inc;
                    end
                    if (table_end) begin
                        seq_data_d = IDLE_WORD;
                        done_d     = 1'b1;
                        state_d    = ST_IDLE;
                    end else begin
                        seq_data_d = ram.rd_data;
                        step_idx_d = next_idx;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
        // Abort wins over start and over any step boundary in the same cycle.
        if (stop) begin
            state_d    = ST_IDLE;
            seq_data_d = IDLE_WORD;
            step_idx_d = step_idx_q;
            rep_idx_d  = rep_idx_q;
            done_d     = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            state_q     <= ST_IDLE;
            seq_data_q  <= IDLE_WORD;
            step_idx_q  <= '0;
            rep_idx_q   <= '0;
            done_q      <= 1'b0;
            num_steps_q <= '0;
            sps_q       <= '0;
            nreps_q     <= '0;
        end else begin
            state_q     <= state_d;
            seq_data_q  <= seq_data_d;
            step_idx_q  <= step_idx_d;
            rep_idx_q   <= rep_idx_d;
            done_q      <= done_d;
            num_steps_q <= num_steps_d;
            sps_q       <= sps_d;
            nreps_q     <= nreps_d;
        end
    end

    // Read port is decoded from registered state so the RAM sees it within the same cycle.
    assign ram.rd_en   = (state_q == ST_FETCH0) || ((state_q == ST_RUN) && prefetch);
    assign ram.rd_addr = ((state_q == ST_RUN) && prefetch) ? next_idx : '0;

    assign seq_data  = seq_data_q;
    assign busy      = (state_q != ST_IDLE);
    assign step_idx  = step_idx_q;
    assign rep_idx   = rep_idx_q;
    assign done      = done_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_sequence_scheduler.sv
// Scoreboard bench for sequence_scheduler: per-cycle expected outputs queued at start, compared at negedge.
module tb_sequence_scheduler;
    import sequence_pkg::*;

    localparam int AW = 10;
    localparam int CW = 32;
    localparam int EW = 184;

    logic            clk = 1'b0;
    logic            aresetn = 1'b0;
    logic            start = 1'b0;
    logic            stop = 1'b0;
    logic [AW:0]     num_steps = '0;
    logic [CW-1:0]   samples_per_step = '0;
    logic [CW-1:0]   num_repetitions = '0;
    logic [127:0]    seq_data;
    logic            busy;
    logic [AW-1:0]   step_idx;
    logic [CW-1:0]   rep_idx;
    logic            done;
    logic [1:0]      state_dbg;

    logic [127:0]    mem [0:(1<<AW)-1];
    logic [EW-1:0]   exp_q [$];
    int              checks = 0;
    int              failures = 0;

    sequence_scheduler_if #(.ADDR_WIDTH(AW)) ram_if ();

    sequence_scheduler #(.ADDR_WIDTH(AW), .CNT_WIDTH(CW)) dut (
        .clk              (clk),
        .aresetn          (aresetn),
        .start            (start),
        .stop             (stop),
        .num_steps        (num_steps),
        .samples_per_step (samples_per_step),
        .num_repetitions  (num_repetitions),
        .ram              (ram_if),
        .seq_data         (seq_data),
        .busy             (busy),
        .step_idx         (step_idx),
        .rep_idx          (rep_idx),
        .done             (done),
        .state_dbg        (state_dbg)
    );

    // Clock / reset / RAM model
    always #5 clk = ~clk;

    always @(posedge clk or negedge aresetn) begin
        if (!aresetn) ram_if.rd_data <= '0;
        else if (ram_if.rd_en) ram_if.rd_data <= mem[ram_if.rd_addr];
    end

    function automatic logic [EW-1:0] mk(logic chk, logic [31:0] rep, logic [9:0] stp, logic dn,
                                          logic bz, logic re, logic [9:0] ad, logic [127:0] sq);
        return {chk, rep, stp, dn, bz, re, ad, sq};
    endfunction

    // Expected per-cycle outputs, first entry is the cycle after the start edge.
    task automatic push_playback(input int n, input int s, input int r);
        int sp;
        sp = (s < 2) ? 2 : s;
        exp_q.push_back(mk(1'b0, 32'd0, 10'd0, 1'b0, 1'b1, 1'b1, 10'd0, 128'd0));
        exp_q.push_back(mk(1'b1, 32'd0, 10'd0, 1'b0, 1'b1, 1'b0, 10'd0, 128'd0));
        for (int rr = 0; rr < r; rr++)
            for (int j = 0; j < n; j++)
                for (int k = 0; k < sp; k++)
                    exp_q.push_back(mk(1'b1, rr, j, 1'b0, 1'b1, (k == sp-2),
                                       (k == sp-2) ? 10'((j+1) % n) : 10'd0, mem[j]));
        exp_q.push_back(mk(1'b0, 32'd0, 10'd0, 1'b1, 1'b0, 1'b0, 10'd0, 128'd0));
        exp_q.push_back(mk(1'b0, 32'd0, 10'd0, 1'b0, 1'b0, 1'b0, 10'd0, 128'd0));
    endtask

    // Drivers
    task automatic kick(input int n, input int s, input int r);
        @(negedge clk);
        num_steps = n[AW:0]; samples_per_step = s; num_repetitions = r; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic check_stream(input string name, input int inj);
        logic [EW-1:0] e;
        int cyc;
        cyc = 0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            cyc++;
            checks++;
            if (seq_data !== e[127:0]) begin
                failures++;
                $display("FAIL %s seq_data cyc=%0d got=%h exp=%h", name, cyc, seq_data, e[127:0]);
            end
            checks++;
            if (ram_if.rd_en !== e[138] || ram_if.rd_addr !== e[137:128]) begin
                failures++;
                $display("FAIL %s rd cyc=%0d got=%b/%0d exp=%b/%0d", name, cyc,
                         ram_if.rd_en, ram_if.rd_addr, e[138], e[137:128]);
            end
            checks++;
            if (busy !== e[139] || done !== e[140]) begin
                failures++;
                $display("FAIL %s busy/done cyc=%0d got=%b/%b exp=%b/%b", name, cyc,
                         busy, done, e[139], e[140]);
            end
            if (e[183]) begin
                checks++;
                if (step_idx !== e[150:141] || rep_idx !== e[182:151]) begin
                    failures++;
                    $display("FAIL %s idx cyc=%0d got=%0d/%0d exp=%0d/%0d", name, cyc,
                             step_idx, rep_idx, e[150:141], e[182:151]);
                end
            end
            if (cyc == inj) begin
                start = 1'b1; num_steps = 1; samples_per_step = 2; num_repetitions = 5;
            end else begin
                start = 1'b0;
            end
            if (exp_q.size() > 0) @(negedge clk);
        end
        start = 1'b0;
    endtask

    task automatic check_idle(input string name);
        checks++;
        if (seq_data !== '0 || busy !== 1'b0 || done !== 1'b0 || ram_if.rd_en !== 1'b0 ||
            ram_if.rd_addr !== '0 || step_idx !== '0 || rep_idx !== '0) begin
            failures++;
            $display("FAIL %s got seq=%h busy=%b done=%b rd_en=%b rd_addr=%0d step=%0d rep=%0d exp all zero",
                     name, seq_data, busy, done, ram_if.rd_en, ram_if.rd_addr, step_idx, rep_idx);
        end
    endtask

    // Scenarios
    task automatic test_reset();
        repeat (3) @(negedge clk);
        check_idle("reset");
        aresetn = 1'b1;
        @(negedge clk);
        check_idle("after_reset");
    endtask

    task automatic test_basic();
        push_playback(3, 4, 1);
        kick(3, 4, 1);
        check_stream("basic", -1);
    endtask

    task automatic test_clamp();
        push_playback(3, 0, 1);
        kick(3, 0, 1);
        check_stream("clamp0", -1);
        push_playback(2, 1, 2);
        kick(2, 1, 2);
        check_stream("clamp1", -1);
    endtask

    task automatic test_repetition();
        push_playback(2, 3, 3);
        kick(2, 3, 3);
        check_stream("rep_wrap", -1);
    endtask

    task automatic test_start_while_busy();
        push_playback(3, 4, 1);
        kick(3, 4, 1);
        check_stream("start_busy", 5);
    endtask

    task automatic test_infinite();
        int done_seen;
        int idx;
        int rep;
        done_seen = 0;
        kick(3, 5, 0);
        for (int c = 1; c < 1000; c++) begin
            if (done === 1'b1) done_seen++;
            @(negedge clk);
        end
        idx = ((1000 - 3) / 5) % 3;
        rep = ((1000 - 3) / 5) / 3;
        checks++;
        if (done_seen != 0 || busy !== 1'b1) begin
            failures++;
            $display("FAIL infinite_run got done_count=%0d busy=%b exp 0/1", done_seen, busy);
        end
        checks++;
        if (seq_data !== mem[idx] || rep_idx !== rep) begin
            failures++;
            $display("FAIL infinite_pos got seq=%h rep=%0d exp seq=%h rep=%0d", seq_data, rep_idx, mem[idx], rep);
        end
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        checks++;
        if (seq_data !== '0 || busy !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("FAIL infinite_stop got seq=%h busy=%b done=%b exp 0/0/0", seq_data, busy, done);
        end
        done_seen = 0;
        repeat (3) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) done_seen++;
        end
        checks++;
        if (done_seen != 0) begin
            failures++;
            $display("FAIL infinite_after_stop got active_cycles=%0d exp 0", done_seen);
        end
    endtask

    task automatic test_simultaneous();
        // stop on the step boundary of word A
        kick(3, 4, 1);
        repeat (5) @(negedge clk);
        checks++;
        if (seq_data !== mem[0]) begin
            failures++;
            $display("FAIL boundary_pre got seq=%h exp=%h", seq_data, mem[0]);
        end
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        checks++;
        if (seq_data !== '0 || busy !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("FAIL boundary_stop got seq=%h busy=%b done=%b exp 0/0/0", seq_data, busy, done);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL boundary_after got busy=%b done=%b exp 0/0", busy, done);
        end
        // start and stop together in IDLE
        @(negedge clk);
        num_steps = 3; samples_per_step = 4; num_repetitions = 1; start = 1'b1; stop = 1'b1;
        @(negedge clk);
        start = 1'b0; stop = 1'b0;
        checks++;
        if (busy !== 1'b0 || ram_if.rd_en !== 1'b0) begin
            failures++;
            $display("FAIL start_stop got busy=%b rd_en=%b exp 0/0", busy, ram_if.rd_en);
        end
        // zero-length table
        kick(0, 4, 1);
        checks++;
        if (busy !== 1'b0 || ram_if.rd_en !== 1'b0) begin
            failures++;
            $display("FAIL zero_steps got busy=%b rd_en=%b exp 0/0", busy, ram_if.rd_en);
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || seq_data !== '0) begin
            failures++;
            $display("FAIL zero_steps_after got busy=%b seq=%h exp 0/0", busy, seq_data);
        end
    endtask

    task automatic test_reset_mid_run();
        kick(3, 4, 2);
        repeat (8) @(negedge clk);
        checks++;
        if (seq_data !== mem[1] || ram_if.rd_en !== 1'b1) begin
            failures++;
            $display("FAIL mid_run_pre got seq=%h rd_en=%b exp %h/1", seq_data, ram_if.rd_en, mem[1]);
        end
        #2 aresetn = 1'b0;
        #1 check_idle("async_reset");
        @(negedge clk);
        aresetn = 1'b1;
        push_playback(3, 4, 1);
        kick(3, 4, 1);
        check_stream("post_reset", -1);
    endtask

    initial begin
        for (int i = 0; i < (1 << AW); i++) mem[i] = {$urandom, $urandom, $urandom, $urandom};
        mem[0] = 128'hA;
        mem[1] = 128'hB;
        mem[2] = 128'hC;
        test_reset();
        test_basic();
        test_clamp();
        test_repetition();
        test_start_while_busy();
        test_infinite();
        test_simultaneous();
        test_reset_mid_run();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sequence_scheduler.md
# sequence_scheduler

Plays a table of 128-bit sequence words out of a BRAM, one word per step. Each word is held for a programmable number of sample clocks, and the whole table is repeated a programmable number of times. The block drives the `seq_data` bus consumed by the sequence slice, which decodes it into DAC/PDM values, enable flags, resync flags and ramp-down flags. It sits between the PS-configured sequence RAM and the slice, in the DAC clock domain.

## Interface
Parameters:
- `ADDR_WIDTH`, 10: sequence RAM address width; maximum table length is 2^ADDR_WIDTH steps.
- `CNT_WIDTH`, 32: width of the samples-per-step and repetition counters.

Ports:
- `clk`, in, 1: sample clock. Only clock.
- `aresetn`, in, 1: asynchronous, active-low reset.
- `start`, in, 1: single-cycle request to begin playback.
- `stop`, in, 1: single-cycle request to abort playback.
- `num_steps`, in, ADDR_WIDTH+1: table length in steps.
- `samples_per_step`, in, CNT_WIDTH: clocks each word is held.
- `num_repetitions`, in, CNT_WIDTH: table passes to play; 0 means infinite.
- `rd_en`, out, 1: sequence RAM read enable.
- `rd_addr`, out, ADDR_WIDTH: sequence RAM read address.
- `rd_data`, in, 128: sequence RAM data, valid one clock after `rd_en`.
- `seq_data`, out, 128: word currently applied, to the sequence slice.
- `busy`, out, 1: high in FETCH and RUN.
- `step_idx`, out, ADDR_WIDTH: table index of the word in `seq_data`.
- `rep_idx`, out, CNT_WIDTH: current pass, starting at 0.
- `done`, out, 1: one-cycle pulse on natural completion.

## Operation
- States: IDLE, FETCH0, FETCH1, RUN.
- **IDLE:**
  - `seq_data` = 0, which means all enables are off.
  - On `start` with `stop` low and `num_steps` != 0, latch all three config inputs and go to FETCH0.
  - `start` with `num_steps` = 0 is ignored.
- **FETCH0:** `rd_en` = 1, `rd_addr` = 0; go to FETCH1.
- **FETCH1:** `seq_data` <= `rd_data`, `step_idx` = 0, step counter = 0; go to RUN.
- **RUN:** the step counter counts 0 to S-1, where S = max(latched `samples_per_step`, 2). Values 0 and 1 clamp to 2.
  - When count = S-2, prefetch: `rd_en` = 1, `rd_addr` = next index.
    - Next index is `step_idx`+1.
    - It wraps to 0 when `step_idx` = `num_steps`-1.
  - When count = S-1 and the table is not ending, load `rd_data` into `seq_data`, update `step_idx`, and reset the counter.
  - On wrap, increment `rep_idx`.
    - If `num_repetitions` != 0 and the incremented `rep_idx` = `num_repetitions`, the table ends.
    - On table end: `seq_data` <= 0, `done` = 1 for one cycle, go to IDLE. The prefetched word is discarded.
- **stop:**
  - In any state, at the next edge: `seq_data` <= 0, go to IDLE, no `done`.
  - `stop` has priority over `start` and over a step boundary in the same cycle.
- `start` while `busy` is ignored. Config input changes while `busy` have no effect.
- All counters use unsigned arithmetic.
  - The step counter never exceeds S-1.
  - `rep_idx` saturates at all-ones in infinite mode; playback continues.

## Timing
- Reset values: `seq_data` 0, `rd_en` 0, `rd_addr` 0, `busy` 0, `step_idx` 0, `rep_idx` 0, `done` 0, state IDLE.
- All outputs are registered. `rd_en` and `rd_addr` are decoded from registered state and counter, so they are valid in the same cycle.
- Start latency: `start` sampled at edge E; `rd_en` is high in cycle E+1; word 0 appears on `seq_data` after edge E+2. That is 3 clocks from `start` to the first word.
- Each word is held exactly S clocks. Transitions between steps and across wraps are gapless.
- The last word is held S clocks, then `seq_data` = 0 in the same cycle `done` is high.
- Reset asserted mid-playback returns all outputs to their reset values immediately (asynchronously).

## Structure
- Shared package `sequence_pkg`:
  - State enum.
  - `SEQ_WORD_W` = 128.
  - Idle word constant, all zeros.
- Sub-module `sequence_step_counter`: a CNT_WIDTH counter with clamp, `prefetch` flag (count = S-2) and `last` flag (count = S-1).
- The top module holds the FSM, address/wrap logic and repetition counter.

## Test plan
- **Basic playback:** `num_steps` = 3, `samples_per_step` = 4, `num_repetitions` = 1, RAM words 0xA/0xB/0xC.
  - `seq_data` = A, B, C for 4 clocks each, first word 3 clocks after `start`.
  - Then `seq_data` = 0 with `done` pulse; total busy time 14 clocks.
- **Clamp:** `samples_per_step` = 0, then 1 → each word held 2 clocks; reads issued every 2 clocks.
- **Repetition and wrap:** `num_steps` = 2, `num_repetitions` = 3.
  - Sequence A B A B A B with no gaps.
  - `rep_idx` steps 0 → 1 → 2; exactly one `done`.
- **Infinite mode:** `num_repetitions` = 0, run 1000 clocks → no `done`; `stop` → `seq_data` = 0 the next cycle, `busy` = 0, no `done`.
- **Simultaneous events:**
  - `stop` on the step-boundary cycle → no load; `seq_data` = 0.
  - `start` and `stop` together in IDLE → stays IDLE.
  - `start` while busy → ignored.
  - `num_steps` = 0 → ignored.
- **Reset mid-run:** drop `aresetn` during RUN → all outputs 0 asynchronously; after release, a new `start` plays from step 0.
